// File: rtl/axis_fifo_frame_arbiter.sv
// Round-robin arbiter that drains whole frames from NUM_CH FWFT FIFOs onto one
// AXI4-Stream master port, re-arbitrating after every TLAST beat.
module axis_fifo_frame_arbiter #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int NUM_CH               = 4,
    parameter int C_M_START_COUNT      = 32,
    parameter int LENGTH_OF_FRAME      = 1024
) (
    input  logic                                     M_AXIS_ACLK,
    input  logic                                     M_AXIS_ARESETN,
    input  logic [NUM_CH*C_M_AXIS_TDATA_WIDTH-1:0]   fifo_dout,
    input  logic [NUM_CH-1:0]                        fifo_empty,
    input  logic [NUM_CH-1:0]                        fifo_prog_empty,
    input  logic [NUM_CH-1:0]                        ch_enable,
    output logic [NUM_CH-1:0]                        fifo_rd_en,
    output logic                                     M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]          M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]        M_AXIS_TKEEP,
    output logic                                     M_AXIS_TLAST,
    input  logic                                     M_AXIS_TREADY,
    output logic [$clog2(NUM_CH)-1:0]                cur_ch,
    output logic                                     frame_done,
    output logic [1:0]                               state_dbg
);

    localparam int W       = C_M_AXIS_TDATA_WIDTH;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int BEAT_W  = $clog2(LENGTH_OF_FRAME) + 1;
    localparam int START_W = $clog2(C_M_START_COUNT) + 1;
    localparam logic [START_W-1:0] START_LAST = START_W'(C_M_START_COUNT - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(LENGTH_OF_FRAME - 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ARB  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [START_W-1:0]  start_cnt, start_cnt_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [CH_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [CH_W-1:0]     cur_ch_nxt;
    logic                frame_done_nxt;

    logic [NUM_CH-1:0]   eligible;
    logic                grant_vld;
    logic [CH_W-1:0]     grant_ch;
    logic [CH_W-1:0]     search_idx;
    logic                hs;
    logic                last_beat;

    assign state_dbg    = state;
    assign eligible     = ch_enable & ~fifo_prog_empty;
    assign M_AXIS_TKEEP = '1;
    assign M_AXIS_TDATA = fifo_dout[cur_ch*W +: W];

    // Handshake: a beat transfers on a cycle where TVALID and TREADY are both
    // high. TVALID only follows the granted FIFO's empty flag, and that FIFO's
    // head advances solely on rd_en, so a stalled beat stays valid and stable.
    assign M_AXIS_TVALID = (state == S_SEND) && !fifo_empty[cur_ch];
    assign hs            = M_AXIS_TVALID && M_AXIS_TREADY;
    assign last_beat     = (beat_cnt == BEAT_LAST);
    assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fifo_rd_en[i] = hs && (cur_ch == CH_W'(i));
        end
    end

    // Rotating-priority search starting just above the last granted channel.
    always_comb begin
        grant_vld  = 1'b0;
        grant_ch   = '0;
        search_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            search_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!grant_vld && eligible[search_idx]) begin
                grant_vld = 1'b1;
                grant_ch  = search_idx;
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state      <= S_WAIT;
            start_cnt  <= '0;
            beat_cnt   <= '0;
            rr_ptr     <= CH_W'(NUM_CH - 1);
            cur_ch     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            start_cnt  <= start_cnt_nxt;
            beat_cnt   <= beat_cnt_nxt;
            rr_ptr     <= rr_ptr_nxt;
            cur_ch     <= cur_ch_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        start_cnt_nxt  = start_cnt;
        beat_cnt_nxt   = beat_cnt;
        rr_ptr_nxt     = rr_ptr;
        cur_ch_nxt     = cur_ch;
        frame_done_nxt = 1'b0;
        case (state)
            S_WAIT: begin
                if (start_cnt == START_LAST) begin
                    state_nxt = S_ARB;
                end else begin
                    start_cnt_nxt = start_cnt + 1'b1;
                end
            end
            S_ARB: begin
                if (grant_vld) begin
                    cur_ch_nxt   = grant_ch;
                    rr_ptr_nxt   = grant_ch;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                // Enable/prog_empty are not consulted here: a started frame always finishes.
                if (hs) begin
                    if (last_beat) begin
                        beat_cnt_nxt   = '0;
                        frame_done_nxt = 1'b1;
                        state_nxt      = S_ARB;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_axis_fifo_frame_arbiter.sv
// Bench for axis_fifo_frame_arbiter: FWFT FIFO models per channel, an expected
// data/channel queue filled on load and drained on each stream handshake.
`timescale 1ns/1ps
module tb_axis_fifo_frame_arbiter;

    localparam int W     = 32;
    localparam int NCH   = 4;
    localparam int LEN   = 8;
    localparam int START = 32;
    localparam int DEPTH = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH*W-1:0]     fifo_dout = '0;
    logic [NCH-1:0]       fifo_empty;
    logic [NCH-1:0]       fifo_prog_empty = '1;
    logic [NCH-1:0]       ch_enable = '1;
    logic [NCH-1:0]       fifo_rd_en;
    logic                 tvalid;
    logic [W-1:0]         tdata;
    logic [W/8-1:0]       tkeep;
    logic                 tlast;
    logic                 tready = 1'b1;
    logic [1:0]           cur_ch;
    logic                 frame_done;
    logic [1:0]           state_dbg;

    // clock / reset
    always #5 clk = ~clk;

    axis_fifo_frame_arbiter #(
        .C_M_AXIS_TDATA_WIDTH(W),
        .NUM_CH(NCH),
        .C_M_START_COUNT(START),
        .LENGTH_OF_FRAME(LEN)
    ) dut (
        .M_AXIS_ACLK(clk),
        .M_AXIS_ARESETN(rst_n),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_prog_empty(fifo_prog_empty),
        .ch_enable(ch_enable),
        .fifo_rd_en(fifo_rd_en),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA(tdata),
        .M_AXIS_TKEEP(tkeep),
        .M_AXIS_TLAST(tlast),
        .M_AXIS_TREADY(tready),
        .cur_ch(cur_ch),
        .frame_done(frame_done),
        .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO models
    logic [W-1:0]   mem [NCH][DEPTH];
    int             wr_p [NCH];
    int             rd_p [NCH];
    int             seq  [NCH];
    logic [NCH-1:0] m_empty = '1;
    logic [NCH-1:0] empty_force = '0;
    logic [NCH-1:0] rd_s;

    assign fifo_empty = m_empty | empty_force;

    task automatic fifo_update();
        for (int i = 0; i < NCH; i++) begin
            m_empty[i]            = (wr_p[i] == rd_p[i]);
            fifo_prog_empty[i]    = ((wr_p[i] - rd_p[i]) < LEN);
            fifo_dout[i*W +: W]   = mem[i][rd_p[i] % DEPTH];
        end
    endtask

    always @(posedge clk) begin
        rd_s = fifo_rd_en;
        #1;
        for (int i = 0; i < NCH; i++) if (rd_s[i]) rd_p[i]++;
        fifo_update();
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           exp_ch_q[$];

    function automatic logic [W-1:0] mk_word(input int ch, input int s, input int b);
        return W'((ch << 24) | ((s & 255) << 16) | b);
    endfunction

    task automatic push_exp_frame(input int ch, input int s);
        for (int b = 0; b < LEN; b++) exp_q.push_back(mk_word(ch, s, b));
        exp_ch_q.push_back(ch);
    endtask

    task automatic load_frame(input int ch, input bit push_exp);
        for (int b = 0; b < LEN; b++) begin
            mem[ch][wr_p[ch] % DEPTH] = mk_word(ch, seq[ch], b);
            wr_p[ch]++;
        end
        if (push_exp) push_exp_frame(ch, seq[ch]);
        seq[ch]++;
    endtask

    // TREADY pattern 1,0,0,1,...
    bit tready_pat = 1'b0;
    int pat_i = 0;
    always @(posedge clk) begin
        #2;
        if (tready_pat) begin
            tready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
            pat_i++;
        end
    end

    // output monitor
    int           beat = 0;
    int           frames_seen = 0;
    int           cur_exp = 0;
    bit           fd_pending = 1'b0;
    bit           prev_v = 1'b0;
    bit           prev_r = 1'b0;
    logic [W-1:0] prev_d = '0;
    bit           gap_mode = 1'b0;
    bit           gap_arm = 1'b0;
    bit           gap_track = 1'b0;
    int           gap_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            beat = 0; fd_pending = 1'b0; prev_v = 1'b0; gap_track = 1'b0;
        end else begin
            check_eq("frame_done", frame_done, fd_pending);
            fd_pending = 1'b0;
            if (prev_v && !prev_r) begin
                check_eq("hold_valid", tvalid, 1);
                check_eq("hold_data", tdata, prev_d);
            end
            if (gap_track) begin
                if (tvalid) begin
                    if (gap_arm && gap_mode) check_eq("idle_gap", gap_cnt, 1);
                    gap_track = 1'b0;
                end else gap_cnt++;
            end
            if (tvalid && tready) begin
                if (beat == 0) begin
                    if (exp_ch_q.size() == 0) begin
                        check_eq("frame_expected", exp_ch_q.size(), 1);
                        cur_exp = -1;
                    end else cur_exp = exp_ch_q.pop_front();
                end
                check_eq("cur_ch", cur_ch, cur_exp);
                check_eq("rd_en", fifo_rd_en, 64'd1 << cur_exp);
                if (exp_q.size() == 0) check_eq("data_expected", exp_q.size(), 1);
                else check_eq("tdata", tdata, exp_q.pop_front());
                check_eq("tlast", tlast, beat == LEN - 1);
                beat++;
                if (beat == LEN) begin
                    beat = 0; frames_seen++; fd_pending = 1'b1;
                    gap_track = 1'b1; gap_cnt = 0; gap_arm = gap_mode;
                end
            end else begin
                check_eq("rd_idle", fifo_rd_en, 0);
                if (!tvalid) check_eq("tlast_idle", tlast, 0);
            end
            prev_v = tvalid; prev_r = tready; prev_d = tdata;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_seen < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check_eq("frame_count", frames_seen, target);
    endtask

    task automatic wait_beat(input int target);
        int n = 0;
        while (beat != target && n < 500) begin
            @(posedge clk);
            n++;
        end
        check_eq("beat_reach", beat, target);
    endtask

    // release reset at a negedge and count edges until the first valid beat
    task automatic release_and_time(input string tag);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (tvalid) break;
        end
        check_eq(tag, n, START + 1);
    endtask

    initial begin
        int rd_before;
        int s2;
        int vc;
        for (int i = 0; i < NCH; i++) begin
            wr_p[i] = 0; rd_p[i] = 0; seq[i] = 0;
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_tlast", tlast, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_cur_ch", cur_ch, 0);
        check_eq("rst_tkeep", tkeep, 4'hf);
        check_eq("rst_state", state_dbg, 0);

        // single frame from channel 2, start-up latency
        load_frame(2, 1);
        release_and_time("first_valid_lat");
        wait_frames(1);

        // backpressure on channel 3
        step();
        rd_before = rd_p[3];
        load_frame(3, 1);
        tready_pat = 1'b1;
        wait_frames(2);
        tready_pat = 1'b0;
        step();
        tready = 1'b1;
        check_eq("pops_ch3", rd_p[3] - rd_before, LEN);

        // all channels ready: rotation 0,1,2,3 twice with one idle cycle between frames
        step();
        gap_mode = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++) load_frame(c, 1);
        wait_frames(10);
        gap_mode = 1'b0;

        // underflow mid-frame on channel 1
        step();
        load_frame(1, 1);
        wait_beat(3);
        #2;
        empty_force[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("underflow_valid", tvalid, 0);
        end
        step();
        empty_force[1] = 1'b0;
        wait_frames(11);

        // channel 2 masked; disabling the active channel mid-frame
        step();
        ch_enable = 4'b1011;
        load_frame(3, 1);
        load_frame(0, 1);
        load_frame(1, 1);
        s2 = seq[2];
        load_frame(2, 0);
        wait_beat(3);
        #2;
        ch_enable = 4'b0011;
        wait_frames(14);
        vc = 0;
        repeat (40) begin
            @(negedge clk);
            if (tvalid) vc++;
        end
        check_eq("ch2_masked", vc, 0);
        push_exp_frame(2, s2);
        step();
        ch_enable = '1;
        wait_frames(15);

        // reset mid-frame at beat 5
        step();
        load_frame(1, 1);
        wait_beat(5);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_tvalid", tvalid, 0);
        check_eq("abort_rd_en", fifo_rd_en, 0);
        check_eq("abort_tlast", tlast, 0);
        check_eq("abort_state", state_dbg, 0);
        step();
        for (int i = 0; i < NCH; i++) rd_p[i] = wr_p[i];
        exp_q.delete();
        exp_ch_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        load_frame(0, 1);
        load_frame(3, 1);
        release_and_time("restart_lat");
        wait_frames(17);

        repeat (5) @(posedge clk);
        check_eq("exp_q_left", exp_q.size(), 0);
        check_eq("exp_ch_left", exp_ch_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
